// File: rtl/ca_pkg.sv
// rtl/ca_pkg.sv - shared constants and state type for the rule110 row scanner
package ca_pkg;

  localparam int CELLS_PER_BLOCK  = 8;
  localparam int WE_N_BIT         = 0;
  localparam int HALT_N_BIT       = 1;
  localparam int ADDR_LSB         = 2;
  localparam int MAX_ADDRESS_BITS = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_SEND,
    S_ADVANCE,
    S_DONE
  } scan_state_t;

endpackage

// File: rtl/ca_row_scanner.sv
// rtl/ca_row_scanner.sv - freezes the rule110 core, streams each next-generation row
// as bytes, then advances the core one generation, for a programmed number of rows
module ca_row_scanner
  import ca_pkg::*;
#(
  parameter int BLOCKS    = 15,
  parameter int ADDR_BITS = 6,
  parameter int GEN_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [GEN_W-1:0]           num_generations,
  input  logic [CELLS_PER_BLOCK-1:0] core_data,
  output logic [7:0]                 core_ctrl,
  output logic [CELLS_PER_BLOCK-1:0] m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [GEN_W-1:0]           gen_count,
  output logic                       busy,
  output logic                       done
);

  scan_state_t            state;
  scan_state_t            next_state;
  logic [ADDR_BITS-1:0]   addr;
  logic [GEN_W-1:0]       n_target;
  logic [GEN_W-1:0]       gen_next;
  logic                   last_addr;
  logic                   handshake;

  assign last_addr = (addr == ADDR_BITS'(BLOCKS - 1));
  assign handshake = m_valid && m_ready;
  assign gen_next  = gen_count + 1'b1;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // The core only ever sees reads: write enable stays inactive, unused address bits stay 0.
  always_comb begin
    core_ctrl                                 = '0;
    core_ctrl[WE_N_BIT]                       = 1'b1;
    core_ctrl[HALT_N_BIT]                     = (state == S_ADVANCE);
    core_ctrl[ADDR_LSB +: MAX_ADDRESS_BITS]   = MAX_ADDRESS_BITS'(addr);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = (num_generations == '0) ? S_DONE : S_SETTLE;
        end
      end
      S_SETTLE:  next_state = S_SAMPLE;
      S_SAMPLE:  next_state = S_SEND;
      S_SEND: begin
        if (handshake) begin
          next_state = last_addr ? S_ADVANCE : S_SETTLE;
        end
      end
      S_ADVANCE: next_state = (gen_next == n_target) ? S_DONE : S_SETTLE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      n_target  <= '0;
      gen_count <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_target  <= num_generations;
            gen_count <= '0;
            addr      <= '0;
          end
        end
        S_SAMPLE: begin
          m_data  <= core_data;
          m_valid <= 1'b1;
          m_last  <= last_addr;
        end
        S_SEND: begin
          if (handshake) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (!last_addr) begin
              addr <= addr + 1'b1;
            end
          end
        end
        S_ADVANCE: begin
          gen_count <= gen_next;
          if (gen_next != n_target) begin
            addr <= '0;
          end
        end
        S_DONE: begin
          addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_row_scanner.sv
// tb/tb_ca_row_scanner.sv - bench for ca_row_scanner with a behavioural rule110 core
module tb_ca_row_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_generations;
  logic [7:0]  core_data;
  logic [7:0]  core_ctrl;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] gen_count;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ca_row_scanner dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .num_generations (num_generations),
    .core_data       (core_data),
    .core_ctrl       (core_ctrl),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_last          (m_last),
    .gen_count       (gen_count),
    .busy            (busy),
    .done            (done)
  );

  function automatic logic [127:0] next_gen(input logic [127:0] c);
    logic [127:0] n;
    logic [7:0]   rule;
    logic [2:0]   idx;
    rule = 8'd110;
    for (int i = 0; i < 128; i++) begin
      idx  = {c[(i + 1) % 128], c[i], c[(i + 127) % 128]};
      n[i] = rule[idx];
    end
    return n;
  endfunction

  // Rule110 core: shows T+1 at the addressed block, copies T+1 into T on halt_n.
  logic [127:0] cells;
  logic [127:0] seed_val;
  logic         seed_load = 1'b0;
  logic [127:0] cells_next;
  int           blk;

  always @(posedge clk) begin
    if (seed_load)         cells <= seed_val;
    else if (core_ctrl[1]) cells <= cells_next;
  end

  always_comb begin
    cells_next = next_gen(cells);
    blk        = (core_ctrl[7:2] == 6'h3f) ? 0 : int'(core_ctrl[5:2]);
    core_data  = cells_next[blk*8 +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_seed(input logic [127:0] s);
    @(negedge clk);
    seed_val  = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  logic [7:0] got_data[$];
  logic       got_last[$];
  int halts, dones, busy_cycles, cyc;

  // mode 0: ready always high, 1: high one cycle in three, 2: random
  task automatic run_scan(input int n, input int mode, input int extra_start, input int reset_byte);
    logic       prev_stall, prev_last, prev_halt;
    logic [7:0] prev_data;
    got_data.delete();
    got_last.delete();
    halts = 0; dones = 0; busy_cycles = 0; cyc = 0;
    prev_stall = 1'b0; prev_halt = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    start           = 1'b1;
    num_generations = 16'(n);
    m_ready         = (mode != 1);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = (extra_start > 0 && cyc + 1 == extra_start);
      if (start) num_generations = 16'd5;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc + 1) % 3 == 0);
        default: m_ready = ($urandom_range(0, 1) == 1);
      endcase
      #2;
      cyc++;
      chk("we_n_high", 32'(core_ctrl[0]), 32'd1);
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (reset_byte >= 0 && m_valid && got_data.size() == reset_byte) begin
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_ctrl", 32'(core_ctrl), 32'h01);
        chk("rst_mid_gen", 32'(gen_count), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_last", 32'(m_last), 32'd0);
        return;
      end
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (core_ctrl[1]) begin
        halts++;
        chk("halt_single_cycle", 32'(prev_halt), 32'd0);
      end
      prev_halt = core_ctrl[1];
      if (busy) busy_cycles++;
      if (done) begin
        dones++;
        break;
      end
    end
    start = 1'b0;
    chk("run_done_seen", 32'(dones), 32'd1);
    @(negedge clk);
    #2;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input logic [127:0] seed, input int n, input string tag);
    logic [7:0]   exp_data[$];
    logic         exp_last[$];
    logic [127:0] row;
    row = seed;
    for (int g = 0; g < n; g++) begin
      row = next_gen(row);
      for (int b = 0; b < 15; b++) begin
        exp_data.push_back(row[b*8 +: 8]);
        exp_last.push_back(b == 14);
      end
    end
    chk({tag, "_count"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
    end
  endtask

  logic [127:0] rseed;
  int           rn;

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    num_generations = '0;
    m_ready         = 1'b0;
    load_seed(128'd1);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_ctrl", 32'(core_ctrl), 32'h01);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gen", 32'(gen_count), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);

    run_scan(3, 0, 0, -1);
    check_stream(128'd1, 3, "n3");
    if (got_data.size() == 45) begin
      chk("row0_first", 32'(got_data[0]), 32'h03);
      chk("row1_first", 32'(got_data[15]), 32'h07);
      chk("row2_first", 32'(got_data[30]), 32'h0D);
    end
    chk("n3_halts", 32'(halts), 32'd3);
    chk("n3_gen", 32'(gen_count), 32'd3);
    chk("n3_cycles", 32'(cyc), 32'd139);

    load_seed(128'd1);
    run_scan(3, 1, 0, -1);
    check_stream(128'd1, 3, "n3_slow");
    chk("n3_slow_halts", 32'(halts), 32'd3);
    chk("n3_slow_gen", 32'(gen_count), 32'd3);

    run_scan(0, 0, 0, -1);
    chk("n0_bytes", 32'(got_data.size()), 32'd0);
    chk("n0_halts", 32'(halts), 32'd0);
    chk("n0_cycles", 32'(cyc), 32'd1);
    chk("n0_busy_cycles", 32'(busy_cycles), 32'd1);
    chk("n0_gen", 32'(gen_count), 32'd0);

    load_seed(128'd1);
    run_scan(2, 0, 20, -1);
    check_stream(128'd1, 2, "restart");
    chk("restart_halts", 32'(halts), 32'd2);
    chk("restart_gen", 32'(gen_count), 32'd2);

    for (int t = 0; t < 2; t++) begin
      rseed = {$urandom(), $urandom(), $urandom(), $urandom()};
      rn    = 1 + $urandom_range(0, 2);
      load_seed(rseed);
      run_scan(rn, 2, 0, -1);
      check_stream(rseed, rn, $sformatf("rand%0d", t));
      chk($sformatf("rand%0d_halts", t), 32'(halts), 32'(rn));
      chk($sformatf("rand%0d_gen", t), 32'(gen_count), 32'(rn));
    end

    load_seed(128'd1);
    run_scan(2, 2, 0, 20);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("in_rst_ctrl", 32'(core_ctrl), 32'h01);
    reset = 1'b0;
    load_seed(128'd1);
    run_scan(1, 0, 0, -1);
    check_stream(128'd1, 1, "after_rst");
    chk("after_rst_gen", 32'(gen_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
